// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver (LSB first, 1 start, DATA_BITS data, 1 stop); define RX_PARITY_EN to add a parity bit check.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd4;
`ifdef RX_PARITY_EN
    localparam logic [2:0] PARITY     = 3'd3;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif
    localparam logic [3:0] MID_CNT  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q, baud_q, tick;
    logic                 armed_q, armed_d;
    logic [2:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d, cnt_wrap;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
`ifdef RX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign tick     = baud & ~baud_q;
    assign cnt_wrap = (cnt_q == LAST_CNT) ? 4'd0 : cnt_q + 4'd1;

    // Line synchronizer and baud rising-edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            baud_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            baud_q    <= baud;
        end
    end

    // Frame deserializer: every decision is taken on a baud tick at the bit centre.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        armed_d   = armed_q | (tick & rx_s_q);
`ifdef RX_PARITY_EN
        par_d     = par_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE: if (armed_q && !rx_s_q) begin
                    state_d = START;
                    cnt_d   = 4'd0;
                    armed_d = 1'b0;
                end
                START: begin
                    cnt_d = (cnt_q == MID_CNT) ? 4'd0 : cnt_q + 4'd1;
                    if (cnt_q == MID_CNT) begin
                        state_d   = rx_s_q ? IDLE : DATA;
                        bit_idx_d = 4'd0;
                    end
                end
                DATA: begin
                    cnt_d = cnt_wrap;
                    if (cnt_q == LAST_CNT) begin
                        shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_idx_d = (bit_idx_q == LAST_BIT) ? 4'd0 : bit_idx_q + 4'd1;
                        state_d   = (bit_idx_q == LAST_BIT) ? AFTER_DATA : DATA;
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    cnt_d = cnt_wrap;
                    if (cnt_q == LAST_CNT) begin
                        par_d   = rx_s_q;
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    cnt_d = cnt_wrap;
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        valid_d = rx_s_q;
                        ferr_d  = !rx_s_q;
                        data_d  = rx_s_q ? shift_q : data_q;
`ifdef RX_PARITY_EN
                        perr_d  = rx_s_q & (par_q != ((^shift_q) ^ (PARITY_ODD != 0)));
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Receiver state and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            bit_idx_q <= 4'd0;
            armed_q   <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            armed_q   <= armed_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

`ifdef RX_PARITY_EN
    // Parity sample held until the stop bit decides the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`endif

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames checked each cycle against a frame-offset receive model.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int DB  = 8;
    localparam int OS  = 16;
    localparam int TP  = 4;
    localparam int BIT = OS * TP;
`ifdef RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (DB + 2 + PAR) * BIT;

    logic          clk = 1'b0, rst_n = 1'b1, baud = 1'b0, rx = 1'b1;
    logic [DB-1:0] data_out;
    logic          data_valid, frame_err, parity_err, busy;
    int            checks = 0, errors = 0, cyc = 0;

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .baud(baud), .rx(rx),
        .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        baud = (cyc % TP == 0);
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    int            t0 = -1, tk = 0, rel, idx;
    bit            armed = 1'b0, pb = 1'b0, d1 = 1'b1, d2 = 1'b1, s, parbit;
    logic [DB-1:0] bits, e_data = '0;
    logic          e_valid = 1'b0, e_ferr = 1'b0, e_perr = 1'b0, e_busy = 1'b0;
    int            vcnt = 0, fcnt = 0, pcnt = 0;
    int            vcyc[$];
    logic [DB-1:0] got[$];

    task automatic model_tick(input bit smp);
        if (t0 < 0 && !smp && armed) begin
            t0 = tk;
            armed = 1'b0;
        end else begin
            armed |= smp;
            if (t0 >= 0) begin
                rel = tk - t0;
                if (rel == OS / 2 && smp) t0 = -1;
                else if (rel > OS / 2 && (rel - OS / 2) % OS == 0) begin
                    idx = (rel - OS / 2) / OS - 1;
                    if (idx < DB) bits[idx] = smp;
                    else if (idx < DB + PAR) parbit = smp;
                    else begin
                        e_valid = smp;
                        e_ferr  = !smp;
                        if (smp) begin
                            e_data = bits;
                            e_perr = (PAR == 1) && ((^bits) != parbit);
                        end
                        t0 = -1;
                    end
                end
            end
        end
        tk++;
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            t0 = -1; armed = 1'b0; pb = 1'b0; d1 = 1'b1; d2 = 1'b1;
            e_valid = 1'b0; e_ferr = 1'b0; e_perr = 1'b0; e_busy = 1'b0; e_data = '0;
        end
        chk("data_valid", int'(data_valid), int'(e_valid));
        chk("frame_err", int'(frame_err), int'(e_ferr));
        chk("parity_err", int'(parity_err), int'(e_perr));
        chk("busy", int'(busy), int'(e_busy));
        chk("data_out", int'(data_out), int'(e_data));
        if (data_valid) begin
            vcnt++;
            vcyc.push_back(cyc);
            got.push_back(data_out);
        end
        fcnt += int'(frame_err);
        pcnt += int'(parity_err);
        if (rst_n) begin
            s = d2; d2 = d1; d1 = rx;
            e_valid = 1'b0; e_ferr = 1'b0; e_perr = 1'b0;
            if (baud && !pb) model_tick(s);
            pb = baud;
            e_busy = (t0 >= 0);
        end
    end

    task automatic hold(input bit v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DB-1:0] d, input bit stop, input bit pbit);
        hold(1'b0, BIT);
        for (int i = 0; i < DB; i++) hold(d[i], BIT);
        if (PAR == 1) hold(pbit, BIT);
        hold(stop, BIT);
        rx = 1'b1;
    endtask

    initial begin
        logic [DB-1:0] d;
        int v0, f0, p0;
        #1 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset data_out", int'(data_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset valid", int'(data_valid), 0);
        hold(1'b1, 2 * BIT);

        v0 = vcnt; f0 = fcnt;
        send(8'h55, 1'b1, ^8'h55);
        hold(1'b1, BIT);
        chk("55 count", vcnt - v0, 1);
        chk("55 data", int'(data_out), 'h55);
        chk("55 model", int'(e_data), 'h55);
        chk("55 ferr", fcnt - f0, 0);

        v0 = vcnt;
        send(8'hA3, 1'b1, ^8'hA3);
        send(8'h0F, 1'b1, ^8'h0F);
        hold(1'b1, BIT);
        chk("b2b count", vcnt - v0, 2);
        if (vcnt - v0 == 2) begin
            chk("b2b first", int'(got[v0]), 'hA3);
            chk("b2b second", int'(got[v0+1]), 'h0F);
            chk("b2b spacing", vcyc[v0+1] - vcyc[v0], FRAME);
        end

        v0 = vcnt; f0 = fcnt;
        hold(1'b0, 5 * TP);
        chk("glitch busy high", int'(busy), 1);
        hold(1'b1, OS * TP);
        chk("glitch valid", vcnt - v0, 0);
        chk("glitch ferr", fcnt - f0, 0);
        chk("glitch busy low", int'(busy), 0);

        v0 = vcnt; f0 = fcnt;
        send(8'hFF, 1'b0, ^8'hFF);
        chk("ferr count", fcnt - f0, 1);
        chk("ferr valid", vcnt - v0, 0);
        chk("ferr hold", int'(data_out), 'h0F);
        hold(1'b1, 2 * BIT);
        v0 = vcnt;
        send(8'h12, 1'b1, ^8'h12);
        hold(1'b1, BIT);
        chk("after ferr count", vcnt - v0, 1);
        chk("after ferr data", int'(data_out), 'h12);

        v0 = vcnt; f0 = fcnt;
        hold(1'b0, 3 * FRAME);
        hold(1'b1, 2 * BIT);
        chk("break ferr", fcnt - f0, 1);
        chk("break valid", vcnt - v0, 0);

        v0 = vcnt;
        d = 8'hC3;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(d[i], BIT);
        rst_n = 1'b0;
        #1;
        chk("arst data_out", int'(data_out), 0);
        chk("arst busy", int'(busy), 0);
        chk("arst valid", int'(data_valid), 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        hold(1'b1, 2 * BIT);
        chk("arst no strobe", vcnt - v0, 0);
        send(8'h3C, 1'b1, ^8'h3C);
        hold(1'b1, BIT);
        chk("3C count", vcnt - v0, 1);
        chk("3C data", int'(data_out), 'h3C);

`ifdef RX_PARITY_EN
        v0 = vcnt; p0 = pcnt;
        send(8'h07, 1'b1, 1'b1);
        hold(1'b1, BIT);
        chk("par ok valid", vcnt - v0, 1);
        chk("par ok perr", pcnt - p0, 0);
        chk("par ok data", int'(data_out), 'h07);
        v0 = vcnt; p0 = pcnt;
        send(8'h07, 1'b1, 1'b0);
        hold(1'b1, BIT);
        chk("par bad valid", vcnt - v0, 1);
        chk("par bad perr", pcnt - p0, 1);
`else
        p0 = pcnt;
`endif

        for (int n = 0; n < 24; n++) begin
            d = DB'($urandom);
            hold(1'b1, $urandom_range(0, 3 * BIT / 2));
            send(d, $urandom_range(0, 7) != 0, (^d) ^ ($urandom_range(0, 3) == 0));
        end
        hold(1'b1, 3 * BIT);
        if (PAR == 0) chk("no parity errors", pcnt - p0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
